// File: rtl/ap_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ap_seq_pkg
//  Description : Shared types and constants for the ap_ctrl stage sequencer:
//                FSM state encoding, latency statistic width and the stage
//                index type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ap_seq_pkg;

    // Width of the per-stage latency counter and statistic registers.
    localparam int STAT_W = 32;

    // Stage index. Two bits, so a sequencer can chain at most four stages.
    typedef logic [1:0] stage_idx_t;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_ISSUE     = 3'd1,
        SEQ_WAIT_DONE = 3'd2,
        SEQ_ADVANCE   = 3'd3,
        SEQ_FINISH    = 3'd4,
        SEQ_ERROR     = 3'd5
    } seq_state_e;

    // Plain vector encodings of the states for the state register.
    localparam logic [2:0] S_IDLE      = SEQ_IDLE;
    localparam logic [2:0] S_ISSUE     = SEQ_ISSUE;
    localparam logic [2:0] S_WAIT_DONE = SEQ_WAIT_DONE;
    localparam logic [2:0] S_ADVANCE   = SEQ_ADVANCE;
    localparam logic [2:0] S_FINISH    = SEQ_FINISH;
    localparam logic [2:0] S_ERROR     = SEQ_ERROR;

endpackage : ap_seq_pkg
`default_nettype wire

// File: rtl/ap_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ap_stage_sequencer_if
//  Description : Bundle of the per-stage ap_ctrl handshake between the
//                sequencer (master) and the chained HLS stages (slave).
//                  stage_ap_start    master -> stage
//                  stage_ap_continue master -> stage
//                  stage_ap_ready    stage  -> master
//                  stage_ap_done     stage  -> master
//  Revision    : 1.0 - initial release
// ============================================================================
interface ap_stage_sequencer_if #(
    parameter int NUM_STAGES = 3
) ();

    logic [NUM_STAGES-1:0] stage_ap_start;
    logic [NUM_STAGES-1:0] stage_ap_continue;
    logic [NUM_STAGES-1:0] stage_ap_ready;
    logic [NUM_STAGES-1:0] stage_ap_done;

    modport master (
        output stage_ap_start,
        output stage_ap_continue,
        input  stage_ap_ready,
        input  stage_ap_done
    );

    modport slave (
        input  stage_ap_start,
        input  stage_ap_continue,
        output stage_ap_ready,
        output stage_ap_done
    );

endinterface : ap_stage_sequencer_if
`default_nettype wire

// File: rtl/ap_stage_sequencer_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ap_stage_timer
//  Description : Saturating per-stage latency counter with timeout compare.
//                  ap_clk, ap_rst_n : clock, async active-low reset
//                  clear            : load 1 (the edge entering the first
//                                     counted cycle)
//                  enable           : increment, saturating at all-ones
//                  count            : current latency in cycles
//                  timeout          : count has reached TIMEOUT_CYCLES
//  Revision    : 1.0 - initial release
// ============================================================================
module ap_stage_timer
    import ap_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clear,
    input  logic              enable,
    output logic [STAT_W-1:0] count,
    output logic              timeout
);

    localparam logic [STAT_W-1:0] C_LIMIT = STAT_W'(TIMEOUT_CYCLES);
    localparam logic [STAT_W-1:0] C_MAX   = '1;

    logic [STAT_W-1:0] r_count;

    // Clearing loads 1 rather than 0 so that the first cycle of a stage
    // already reads as latency 1.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= STAT_W'(1);
        end else if (enable && (r_count != C_MAX)) begin
            r_count <= r_count + STAT_W'(1);
        end
    end

    assign count   = r_count;
    assign timeout = (r_count >= C_LIMIT);

endmodule : ap_stage_timer
`default_nettype wire

// File: rtl/ap_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ap_stage_sequencer
//  Description : Runs a chain of ap_ctrl HLS stages one after another,
//                measures each stage's start-to-done latency and aborts a
//                stage that exceeds TIMEOUT_CYCLES.
//                  ap_clk, ap_rst_n : clock, async active-low reset
//                  run_start        : request one pass over all stages
//                  run_busy         : pass in progress
//                  run_done         : one-cycle pulse at the end of a pass
//                  run_error        : sticky timeout flag
//                  err_stage        : stage that timed out
//                  stat_sel         : stage selected for latency readback
//                  stat_cycles      : last latency of stage stat_sel
//                  stg              : per-stage ap_ctrl handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module ap_stage_sequencer
    import ap_seq_pkg::*;
#(
    parameter int          NUM_STAGES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 run_start,
    output logic                 run_busy,
    output logic                 run_done,
    output logic                 run_error,
    output stage_idx_t           err_stage,
    input  stage_idx_t           stat_sel,
    output logic [STAT_W-1:0]    stat_cycles,
    ap_stage_sequencer_if.master stg
);

    localparam stage_idx_t C_LAST_IDX = stage_idx_t'(NUM_STAGES - 1);

    logic [2:0]            r_state;
    stage_idx_t            r_idx;
    logic                  r_run_error;
    stage_idx_t            r_err_stage;
    logic [STAT_W-1:0]     r_stat [NUM_STAGES];

    logic [NUM_STAGES-1:0] w_sel;
    logic                  w_in_stage;
    logic                  w_done_act;
    logic                  w_ready_act;
    logic                  w_enter_issue;
    logic                  w_last;
    logic [STAT_W-1:0]     w_count;
    logic                  w_timeout;

    // One-hot decode of the active stage; all handshake inputs are masked
    // with it so that other stages' ready/done cannot influence the FSM.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_idx == stage_idx_t'(i)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    assign w_in_stage    = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE);
    assign w_done_act    = |(stg.stage_ap_done & w_sel);
    assign w_ready_act   = |(stg.stage_ap_ready & w_sel);
    assign w_last        = (r_idx == C_LAST_IDX);
    assign w_enter_issue = ((r_state == S_IDLE) && run_start) ||
                           ((r_state == S_ADVANCE) && !w_last);

    ap_stage_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clear    (w_enter_issue),
        .enable   (w_in_stage),
        .count    (w_count),
        .timeout  (w_timeout)
    );

    // Done wins over timeout in the same cycle: the stage finished in time.
    // A done without a preceding ready implies the start was consumed.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_run_error <= 1'b0;
            r_err_stage <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run_start) begin
                        r_idx       <= '0;
                        r_run_error <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_done_act) begin
                        r_state <= S_ADVANCE;
                    end else if (w_timeout) begin
                        r_run_error <= 1'b1;
                        r_err_stage <= r_idx;
                        r_state     <= S_ERROR;
                    end else if (w_ready_act) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_done_act) begin
                        r_state <= S_ADVANCE;
                    end else if (w_timeout) begin
                        r_run_error <= 1'b1;
                        r_err_stage <= r_idx;
                        r_state     <= S_ERROR;
                    end
                end
                S_ADVANCE: begin
                    if (w_last) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_idx   <= r_idx + stage_idx_t'(1);
                        r_state <= S_ISSUE;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                S_ERROR:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Latency of the active stage is captured in the cycle done is seen.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (w_in_stage && w_done_act && w_sel[i]) begin
                    r_stat[i] <= w_count;
                end
            end
        end
    end

    always_comb begin
        stat_cycles = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stat_sel == stage_idx_t'(i)) begin
                stat_cycles = r_stat[i];
            end
        end
    end

    // Outputs decode from state so that an asynchronous reset clears them
    // immediately; continue is a same-cycle acknowledge of the active done.
    assign stg.stage_ap_start    = (r_state == S_ISSUE) ? w_sel : '0;
    assign stg.stage_ap_continue = w_in_stage ? (stg.stage_ap_done & w_sel) : '0;

    assign run_busy  = (r_state != S_IDLE);
    assign run_done  = (r_state == S_FINISH);
    assign run_error = r_run_error;
    assign err_stage = r_err_stage;

endmodule : ap_stage_sequencer
`default_nettype wire

// File: tb/tb_ap_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ap_stage_sequencer
//  Description : Self-checking bench for ap_stage_sequencer with behavioural
//                ap_ctrl stage models and a scoreboard of expected run
//                outcomes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_stage_sequencer;
    import ap_seq_pkg::*;

    localparam int NS = 3;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run_start;
    logic              run_busy;
    logic              run_done;
    logic              run_error;
    stage_idx_t        err_stage;
    stage_idx_t        stat_sel;
    logic [STAT_W-1:0] stat_cycles;

    ap_stage_sequencer_if #(.NUM_STAGES(NS)) stg_if ();

    ap_stage_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ap_clk      (clk),
        .ap_rst_n    (rst_n),
        .run_start   (run_start),
        .run_busy    (run_busy),
        .run_done    (run_done),
        .run_error   (run_error),
        .err_stage   (err_stage),
        .stat_sel    (stat_sel),
        .stat_cycles (stat_cycles),
        .stg         (stg_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_stage;
        logic [31:0] cycles;   // run_done or run_error cycle after run_start
        logic [31:0] lat0;
        logic [31:0] lat1;
        logic [31:0] lat2;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t mk_exp(input logic d, input logic e, input logic [1:0] s,
                                    input int cyc, input int l0, input int l1, input int l2);
        exp_t x;
        x.exp_done  = d;
        x.exp_err   = e;
        x.exp_stage = s;
        x.cycles    = 32'(cyc);
        x.lat0      = 32'(l0);
        x.lat1      = 32'(l1);
        x.lat2      = 32'(l2);
        return x;
    endfunction

    // ---------------- stage models ----------------
    // Each stage counts cycles from the first cycle its ap_start is seen
    // (count 1), raises ready while started and count >= rlat, and pulses
    // done when count == dlat. Outputs change on the falling edge.
    int          rlat [NS];
    int          dlat [NS];
    bit          no_done [NS];
    bit          act [NS];
    int          mcnt [NS];
    logic [NS-1:0] spur;

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst_n || !run_busy) begin
                act[i]  = 1'b0;
                mcnt[i] = 0;
            end else if (act[i]) begin
                mcnt[i]++;
            end else if (stg_if.stage_ap_start[i]) begin
                act[i]  = 1'b1;
                mcnt[i] = 1;
            end
            stg_if.stage_ap_ready[i] = act[i] && stg_if.stage_ap_start[i] && (mcnt[i] >= rlat[i]);
            stg_if.stage_ap_done[i]  = (act[i] && !no_done[i] && (mcnt[i] == dlat[i])) || spur[i];
            if (act[i] && !no_done[i] && (mcnt[i] == dlat[i])) act[i] = 1'b0;
        end
    end

    // ---------------- run driver / monitor ----------------
    int            done_cyc, err_cyc, done_cnt;
    bit            busy_after, overlap;
    int            cont_cnt [NS];
    logic [NS-1:0] err_start;

    task automatic set_cfg(input int r, input int d0, input int d1, input int d2, input bit nd1);
        for (int i = 0; i < NS; i++) begin
            rlat[i]    = r;
            no_done[i] = 1'b0;
        end
        dlat[0] = d0; dlat[1] = d1; dlat[2] = d2;
        no_done[1] = nd1;
    endtask

    task automatic check_stats(input string tag, input exp_t e);
        stat_sel = 2'd0; #1; check_val({tag, "_stat0"}, stat_cycles, e.lat0);
        stat_sel = 2'd1; #1; check_val({tag, "_stat1"}, stat_cycles, e.lat1);
        stat_sel = 2'd2; #1; check_val({tag, "_stat2"}, stat_cycles, e.lat2);
        stat_sel = 2'd0;
    endtask

    task automatic reset_probe();
        rst_n = 1'b0;
        #1;
        check_val("rst_start", 32'(stg_if.stage_ap_start), 32'd0);
        check_val("rst_cont",  32'(stg_if.stage_ap_continue), 32'd0);
        check_val("rst_busy",  32'(run_busy), 32'd0);
        check_val("rst_err",   32'(run_error), 32'd0);
        check_val("rst_estg",  32'(err_stage), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // mode 0: plain run, 1: run_start while busy + spurious stage-2 done,
    // 2: reset while stage 1 waits for done.
    task automatic run_once(input string tag, input int mode, input exp_t e_in);
        exp_t e;
        bit   ended;
        bit   s1_seen;
        done_cyc = 0; err_cyc = 0; done_cnt = 0;
        busy_after = 1'b0; overlap = 1'b0; err_start = '0;
        for (int i = 0; i < NS; i++) cont_cnt[i] = 0;
        ended = 1'b0; s1_seen = 1'b0;

        @(negedge clk);
        run_start = 1'b1;
        sb.push_back(e_in);
        for (int c = 1; c <= 400 && !ended; c++) begin
            @(negedge clk);
            #1;
            run_start = 1'b0;
            spur      = '0;
            if ($countones(stg_if.stage_ap_start) > 1) overlap = 1'b1;
            for (int i = 0; i < NS; i++)
                if (stg_if.stage_ap_continue[i]) cont_cnt[i]++;
            if (c == 1) check_val({tag, "_errclr"}, 32'(run_error), 32'd0);
            if (mode == 1 && c == 5) begin
                run_start = 1'b1;
                spur[2]   = 1'b1;
            end
            if (run_done) begin
                done_cnt++;
                done_cyc = c;
                ended    = 1'b1;
            end
            if (run_error) begin
                err_cyc   = c;
                err_start = stg_if.stage_ap_start;
                ended     = 1'b1;
            end
            if (mode == 2) begin
                if (stg_if.stage_ap_start[1]) s1_seen = 1'b1;
                else if (s1_seen) begin
                    reset_probe();
                    ended = 1'b1;
                end
            end
        end
        check_val({tag, "_ended"}, 32'(ended), 32'd1);

        @(negedge clk);
        #1;
        run_start = 1'b0;
        spur      = '0;
        check_val({tag, "_busydrop"}, 32'(run_busy), 32'd0);
        repeat (20) begin
            @(negedge clk);
            #1;
            if (run_done) done_cnt++;
            if (run_busy) busy_after = 1'b1;
        end

        e = sb.pop_front();
        check_val({tag, "_ndone"},   32'(done_cnt), e.exp_done ? 32'd1 : 32'd0);
        check_val({tag, "_busyaft"}, 32'(busy_after), 32'd0);
        check_val({tag, "_overlap"}, 32'(overlap), 32'd0);
        check_val({tag, "_runerr"},  32'(run_error), 32'(e.exp_err));
        if (e.exp_done) begin
            check_val({tag, "_cycles"}, 32'(done_cyc), e.cycles);
            for (int i = 0; i < NS; i++)
                check_val({tag, "_cont"}, 32'(cont_cnt[i]), 32'd1);
        end
        if (e.exp_err) begin
            check_val({tag, "_errcyc"}, 32'(err_cyc), e.cycles);
            check_val({tag, "_errstg"}, 32'(err_stage), 32'(e.exp_stage));
            check_val({tag, "_errstart"}, 32'(err_start), 32'd0);
        end
        check_stats(tag, e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b1;
        run_start = 1'b0;
        stat_sel  = 2'd0;
        spur      = '0;
        set_cfg(2, 10, 40, 25, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_val("init_busy",  32'(run_busy), 32'd0);
        check_val("init_done",  32'(run_done), 32'd0);
        check_val("init_err",   32'(run_error), 32'd0);
        check_val("init_estg",  32'(err_stage), 32'd0);
        check_val("init_start", 32'(stg_if.stage_ap_start), 32'd0);
        check_val("init_cont",  32'(stg_if.stage_ap_continue), 32'd0);
        check_stats("init", mk_exp(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Stage latencies D give run_done at sum(D+1)+1 cycles after start.
        run_once("normal", 0, mk_exp(1, 0, 0, 79, 10, 40, 25));

        set_cfg(1, 1, 1, 1, 1'b0);
        run_once("single", 0, mk_exp(1, 0, 0, 7, 1, 1, 1));

        set_cfg(2, 10, 40, 25, 1'b0);
        run_once("ignore", 1, mk_exp(1, 0, 0, 79, 10, 40, 25));

        // Stage 1 starts at cycle 12, hits 64 at cycle 75, ERROR at 76.
        set_cfg(2, 10, 40, 25, 1'b1);
        run_once("timeout", 0, mk_exp(0, 1, 1, 76, 10, 40, 25));

        set_cfg(2, 10, 40, 25, 1'b0);
        run_once("reset", 2, mk_exp(0, 0, 0, 0, 0, 0, 0));

        run_once("after", 0, mk_exp(1, 0, 0, 79, 10, 40, 25));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule : tb_ap_stage_sequencer
`default_nettype wire
